serializer: RTL and testbench
=============================

// Module: serializer
// PURPOSE
//  Parallel-to-serial transmitter: the transmit-side counterpart of the deserializer in top.
//  Accepts WIDTH-bit words on a valid/ready handshake into a one-word holding buffer.
//  Shifts each word out one bit per cycle on data_out, with a write_out strobe per bit.
//  Drives the serial pair consumed by the deserializer and honours its bit-level flow control.
// PARAMETERS
//  WIDTH      8   word width in bits (>=2)
//  MSB_FIRST  1   1: bit WIDTH-1 sent first; 0: bit 0 sent first
// PORTS
//  clock          in   1      system clock; all state on rising edge
//  reset          in   1      asynchronous, active-low; clears all state immediately
//  data_in        in   WIDTH  parallel word to transmit
//  valid_in       in   1      data_in valid; transfer on edge with valid_in & ready_out
//  ready_out      out  1      holding buffer empty (= ~hold_full)
//  rx_ready_in    in   1      downstream can take a bit this cycle
//  data_out       out  1      serial bit, registered
//  write_out      out  1      data_out carries a new bit this cycle, registered
//  word_done_out  out  1      one-cycle pulse coincident with last bit's write_out
//  busy_out       out  1      state != IDLE
// BEHAVIOUR
//  Reset (reset=0): state=IDLE, hold_full=0, shreg=0, cnt=0, data_out=0, write_out=0,
//   word_done_out=0, busy_out=0, ready_out=1. A word in flight or buffered is discarded.
//  Accept: edge with valid_in=1 & ready_out=1 -> hold<=data_in, hold_full<=1.
//   valid_in while ready_out=0 is ignored (no overwrite, no error).
//  FSM states IDLE, LOAD, SHIFT:
//   IDLE : hold_full=1 -> LOAD.
//   LOAD : shreg<=hold, cnt<=WIDTH, hold_full<=0 (ready_out high next cycle) -> SHIFT.
//   SHIFT: on each edge with rx_ready_in=1: data_out<=next bit (MSB or LSB per MSB_FIRST),
//     write_out<=1, shift shreg, cnt<=cnt-1. rx_ready_in=0: write_out<=0, data_out holds,
//     shreg/cnt unchanged (stall any number of cycles).
//     When emitting the last bit (cnt==1): word_done_out<=1; if hold_full, shreg<=hold,
//     cnt<=WIDTH, hold_full<=0, stay SHIFT (back-to-back, zero gap bits); else -> IDLE.
//  Latency: word accepted at edge N -> first write_out high after edge N+3, with
//   rx_ready_in=1 throughout. Throughput: 1 word per WIDTH cycles when streaming.
//  Accept and internal move of hold on the same edge cannot collide: ready_out=0 then.
//  A new word may be accepted during LOAD/SHIFT once hold_full=0.
//  cnt is $clog2(WIDTH+1) bits; never underflows: SHIFT is left or reloaded at cnt==1.
//  write_out=0 in IDLE and LOAD; data_out keeps its last value there.
// STRUCTURE
//  Package serializer_pkg: typedef enum logic [1:0] {IDLE, LOAD, SHIFT} ser_state_t;
//   localparam SER_WIDTH_DEFAULT = 8. Include it from the shared package area.
//  Single module; holding buffer, FSM and shift register inline.
//  No sub-module required; shifter is under 30 lines.
// TESTING
//  1 Assert reset mid-run -> all outputs at reset values within same cycle, ready_out=1.
//  2 Send 0xA5 (MSB_FIRST=1), rx_ready_in=1 -> 8 consecutive write_out cycles carrying
//    1,0,1,0,0,1,0,1; word_done_out on 8th only.
//  3 Send 0xA5 then 0x3C as early as ready_out allows -> 16 contiguous write_out cycles,
//    bits 10100101 00111100, two word_done_out pulses.
//  4 0xFF with rx_ready_in toggling 1,0,1,0 -> write_out mirrors rx_ready_in;
//    8 bits total, no duplicates or drops.
//  5 Three words pushed while first shifts -> third ignored while ready_out=0;
//    only words 1,2 appear.
//  6 MSB_FIRST=0, send 0x01 -> first bit 1 then seven 0s; reset during bit 4 -> write_out
//    stops, next word 0x80 transmits cleanly.
//  Bench loops data_out/write_out into deserializer and checks recovered words equal sent.

Source files
------------

// File: rtl/serializer_pkg.sv
// serializer_pkg: shared FSM state type and default word width for the serializer
package serializer_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} ser_state_t;
  localparam int SER_WIDTH_DEFAULT = 8;
endpackage

// File: rtl/serializer.sv
// serializer: one-word buffered parallel-to-serial transmitter with bit-level flow control
module serializer
  import serializer_pkg::*;
#(
  parameter int WIDTH     = SER_WIDTH_DEFAULT,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic             rx_ready_in,
  output logic             data_out,
  output logic             write_out,
  output logic             word_done_out,
  output logic             busy_out
);
  localparam int CW = $clog2(WIDTH + 1);
  ser_state_t       r_state;
  logic [WIDTH-1:0] r_hold;
  logic             r_hold_full;
  logic [WIDTH-1:0] r_shreg;
  logic [CW-1:0]    r_cnt;
  logic             r_data;
  logic             r_write;
  logic             r_done;
  logic             w_accept;
  logic             w_bit;
  logic [WIDTH-1:0] w_shifted;
  logic             w_last;
  assign w_accept      = valid_in & ~r_hold_full;
  assign w_bit         = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];
  assign w_shifted     = MSB_FIRST ? {r_shreg[WIDTH-2:0], 1'b0} : {1'b0, r_shreg[WIDTH-1:1]};
  assign w_last        = (r_cnt == CW'(1));
  assign ready_out     = ~r_hold_full;
  assign data_out      = r_data;
  assign write_out     = r_write;
  assign word_done_out = r_done;
  assign busy_out      = (r_state != IDLE);
  // Holding buffer, FSM and shifter; hold is only written when empty and only drained when full
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_shreg     <= '0;
      r_cnt       <= '0;
      r_data      <= 1'b0;
      r_write     <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_write <= 1'b0;
      r_done  <= 1'b0;
      if (w_accept) begin
        r_hold      <= data_in;
        r_hold_full <= 1'b1;
      end
      case (r_state)
        IDLE: if (r_hold_full) r_state <= LOAD;
        LOAD: begin
          r_shreg     <= r_hold;
          r_cnt       <= CW'(WIDTH);
          r_hold_full <= 1'b0;
          r_state     <= SHIFT;
        end
        SHIFT: if (rx_ready_in) begin
          r_data  <= w_bit;
          r_write <= 1'b1;
          r_shreg <= w_shifted;
          r_cnt   <= r_cnt - CW'(1);
          if (w_last) begin
            r_done <= 1'b1;
            if (r_hold_full) begin
              r_shreg     <= r_hold;
              r_cnt       <= CW'(WIDTH);
              r_hold_full <= 1'b0;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serializer.sv
// tb_serializer: MSB-first and LSB-first serializers driven side by side, checked against a bit-collecting receiver model
module tb_serializer;
  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       valid_in = 1'b0;
  logic       rx_ready_in = 1'b0;
  logic       ready_m, dout_m, wr_m, done_m, busy_m;
  logic       ready_l, dout_l, wr_l, done_l, busy_l;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] sent[$];
  logic [7:0] rec_m[$];
  logic [7:0] rec_l[$];
  logic [7:0] acc_m, acc_l;
  int         nb_m, nb_l;
  logic       last_acc;

  always #5 clock = ~clock;

  serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clock(clock), .reset(reset), .data_in(data_in), .valid_in(valid_in), .ready_out(ready_m),
    .rx_ready_in(rx_ready_in), .data_out(dout_m), .write_out(wr_m), .word_done_out(done_m), .busy_out(busy_m)
  );

  serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clock(clock), .reset(reset), .data_in(data_in), .valid_in(valid_in), .ready_out(ready_l),
    .rx_ready_in(rx_ready_in), .data_out(dout_l), .write_out(wr_l), .word_done_out(done_l), .busy_out(busy_l)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic ebit(input logic [7:0] w, input int i, input bit msb);
    return msb ? w[7-i] : w[i];
  endfunction

  task automatic clear_model;
    sent.delete();
    rec_m.delete();
    rec_l.delete();
    acc_m = 8'h00;
    acc_l = 8'h00;
    nb_m = 0;
    nb_l = 0;
  endtask

  // one clock: note handshake, then sample outputs 1 time unit after the edge and feed the receivers
  task automatic tick;
    logic a;
    a = valid_in & ready_m;
    @(posedge clock);
    #1;
    last_acc = a;
    if (a) sent.push_back(data_in);
    if (wr_m) begin
      acc_m = acc_m | (8'(dout_m) << (7 - nb_m));
      nb_m++;
    end
    if (wr_m || done_m) chk("done_m", done_m, wr_m && nb_m == 8);
    if (nb_m == 8) begin
      rec_m.push_back(acc_m);
      acc_m = 8'h00;
      nb_m = 0;
    end
    if (wr_l) begin
      acc_l = acc_l | (8'(dout_l) << nb_l);
      nb_l++;
    end
    if (wr_l || done_l) chk("done_l", done_l, wr_l && nb_l == 8);
    if (nb_l == 8) begin
      rec_l.push_back(acc_l);
      acc_l = 8'h00;
      nb_l = 0;
    end
  endtask

  task automatic send(input logic [7:0] w);
    data_in = w;
    valid_in = 1'b1;
    last_acc = 1'b0;
    for (int t = 0; t < 60; t++) begin
      tick;
      if (last_acc) break;
    end
    if (!last_acc) chk("send_timeout", 0, 1);
    valid_in = 1'b0;
  endtask

  task automatic wait_idle;
    for (int t = 0; t < 200; t++) begin
      if (!busy_m && !busy_l && ready_m && ready_l) break;
      tick;
    end
    chk("idle_timeout", {busy_m, busy_l, ready_m, ready_l}, 4'b0011);
  endtask

  task automatic wait_write_l;
    for (int t = 0; t < 20; t++) begin
      if (wr_l) break;
      tick;
    end
    chk("wr_l_timeout", wr_l, 1);
  endtask

  // asynchronous reset in the middle of a cycle, outputs checked before any clock edge
  task automatic pulse_reset;
    #2;
    reset = 1'b0;
    #1;
    chk("rst_ready", {ready_m, ready_l}, 2'b11);
    chk("rst_write", {wr_m, wr_l}, 2'b00);
    chk("rst_done", {done_m, done_l}, 2'b00);
    chk("rst_busy", {busy_m, busy_l}, 2'b00);
    chk("rst_data", {dout_m, dout_l}, 2'b00);
    clear_model;
    #2;
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] w1, w2, w3;
    logic prx;
    int n, dn;
    bit st;
    clear_model;
    repeat (2) @(posedge clock);
    #1;
    chk("por_ready", ready_m, 1);
    chk("por_write", wr_m, 0);
    chk("por_busy", busy_m, 0);
    reset = 1'b1;

    // reset mid-shift
    rx_ready_in = 1'b1;
    send(8'h5A);
    repeat (5) tick;
    chk("t1_busy_before", busy_m, 1);
    pulse_reset;
    tick;
    chk("t1_after_write", wr_m, 0);

    // single word, latency and bit order
    clear_model;
    send(8'hA5);
    chk("t2_ready_n", ready_m, 0);
    tick;
    chk("t2_lat1", wr_m, 0);
    tick;
    chk("t2_lat2", wr_m, 0);
    chk("t2_ready_back", ready_m, 1);
    for (int i = 0; i < 8; i++) begin
      tick;
      chk("t2_wr", wr_m, 1);
      chk("t2_bit_m", dout_m, ebit(8'hA5, i, 1'b1));
      chk("t2_bit_l", dout_l, ebit(8'hA5, i, 1'b0));
      chk("t2_done", done_m, i == 7);
    end
    tick;
    chk("t2_wr_end", wr_m, 0);
    chk("t2_busy_end", busy_m, 0);
    chk("t2_rec_n", rec_m.size(), 1);
    if (rec_m.size() > 0) chk("t2_rec_m", rec_m[0], 8'hA5);
    if (rec_l.size() > 0) chk("t2_rec_l", rec_l[0], 8'hA5);

    // back-to-back words, no gap bit
    clear_model;
    send(8'hA5);
    send(8'h3C);
    for (int t = 0; t < 10; t++) begin
      if (wr_m) break;
      tick;
    end
    dn = 0;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) tick;
      chk("t3_wr", wr_m, 1);
      chk("t3_bit", dout_m, ebit(k < 8 ? 8'hA5 : 8'h3C, k % 8, 1'b1));
      if (done_m) dn++;
    end
    tick;
    chk("t3_wr_end", wr_m, 0);
    chk("t3_done_n", dn, 2);
    chk("t3_rec_n", rec_m.size(), 2);
    if (rec_m.size() == 2) chk("t3_rec", {rec_m[0], rec_m[1]}, 16'hA53C);

    // stalls: write_out follows rx_ready_in
    clear_model;
    rx_ready_in = 1'b1;
    send(8'hFF);
    n = 0;
    st = 1'b0;
    for (int t = 0; t < 60 && n < 8; t++) begin
      prx = rx_ready_in;
      tick;
      if (wr_m) st = 1'b1;
      if (st) chk("t4_mirror", wr_m, prx);
      if (wr_m) begin
        n++;
        chk("t4_bit", dout_m, 1);
      end
      rx_ready_in = ~rx_ready_in;
    end
    rx_ready_in = 1'b1;
    for (int t = 0; t < 3; t++) begin
      tick;
      chk("t4_extra", wr_m, 0);
    end
    chk("t4_n", n, 8);
    chk("t4_rec_n", rec_m.size(), 1);
    if (rec_m.size() > 0) chk("t4_rec", rec_m[0], 8'hFF);

    // third word offered while buffer full is ignored
    clear_model;
    w1 = 8'($urandom);
    w2 = 8'($urandom);
    w3 = 8'($urandom);
    send(w1);
    send(w2);
    data_in = w3;
    valid_in = 1'b1;
    for (int t = 0; t < 4; t++) begin
      chk("t5_ready", ready_m, 0);
      tick;
      chk("t5_acc", last_acc, 0);
    end
    valid_in = 1'b0;
    wait_idle;
    chk("t5_rec_n", rec_m.size(), 2);
    if (rec_m.size() == 2) chk("t5_rec_m", {rec_m[0], rec_m[1]}, {w1, w2});
    if (rec_l.size() == 2) chk("t5_rec_l", {rec_l[0], rec_l[1]}, {w1, w2});

    // LSB-first, reset during bit 4, then a clean word
    clear_model;
    send(8'h01);
    wait_write_l;
    chk("t6_b0", dout_l, 1);
    for (int k = 1; k < 4; k++) begin
      tick;
      chk("t6_wr", wr_l, 1);
      chk("t6_b", dout_l, 0);
    end
    pulse_reset;
    tick;
    chk("t6_stop", wr_l, 0);
    chk("t6_busy", busy_l, 0);
    send(8'h80);
    wait_write_l;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick;
      chk("t6_wr2", wr_l, 1);
      chk("t6_bit2", dout_l, k == 7);
    end
    tick;
    chk("t6_rec_n", rec_l.size(), 1);
    if (rec_l.size() > 0) chk("t6_rec_l", rec_l[0], 8'h80);
    if (rec_m.size() > 0) chk("t6_rec_m", rec_m[0], 8'h80);

    // random traffic and random back-pressure
    clear_model;
    for (int c = 0; c < 400; c++) begin
      valid_in = 1'($urandom % 2);
      data_in = 8'($urandom);
      rx_ready_in = ($urandom % 4) != 0;
      prx = rx_ready_in;
      tick;
      if (wr_m) chk("rnd_gate", prx, 1);
    end
    valid_in = 1'b0;
    rx_ready_in = 1'b1;
    wait_idle;
    chk("rnd_n_m", rec_m.size(), sent.size());
    chk("rnd_n_l", rec_l.size(), sent.size());
    for (int i = 0; i < sent.size(); i++) begin
      if (i < rec_m.size()) chk("rnd_word_m", rec_m[i], sent[i]);
      if (i < rec_l.size()) chk("rnd_word_l", rec_l[i], sent[i]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
